// File: rtl/scal_counter.sv
// -----------------------------------------------------------------------------
// scal_counter
//
// Gated rate counter for the stretched trigger one-shot scaler pulses. Each
// channel counts rising edges of its scal_i bit over a fixed window of
// GATE_CYCLES clk250_i cycles. At the window end the counts are latched and
// done_o pulses. Latched values are read through a registered
// request/acknowledge port.
//
// Ports:
//   clk250_i   250 MHz system clock, all logic on the rising edge
//   rst_i      synchronous active-high reset
//   scal_i     stretched scaler pulses, one bit per channel (clk250_i domain)
//   rd_i       single-cycle read strobe
//   rd_addr_i  channel to read; addresses >= NCHAN read as zero
//   rd_data_o  latched count of the addressed channel (valid with rd_ack_o)
//   rd_ovf_o   overflow flag of the addressed channel for that window
//   rd_ack_o   read data valid, one cycle after rd_i
//   done_o     one-cycle pulse when a new window has been latched
//   seq_o      window sequence number, increments at each latch, wraps
// -----------------------------------------------------------------------------
module scal_counter #(
   parameter int NCHAN       = 4,
   parameter int COUNT_WIDTH = 16,
   parameter int GATE_CYCLES = 250000,
   parameter int ADDR_WIDTH  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                   clk250_i,
   input  logic                   rst_i,
   input  logic [NCHAN-1:0]       scal_i,
   input  logic                   rd_i,
   input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
   output logic [COUNT_WIDTH-1:0] rd_data_o,
   output logic                   rd_ovf_o,
   output logic                   rd_ack_o,
   output logic                   done_o,
   output logic [7:0]             seq_o
);

   localparam int GCNT_WIDTH = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GCNT_WIDTH-1:0]  GCNT_LAST = GCNT_WIDTH'(GATE_CYCLES - 1);
   localparam logic [GCNT_WIDTH-1:0]  GCNT_ONE  = GCNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
   // One extra bit so NCHAN itself is representable for the range check.
   localparam logic [ADDR_WIDTH:0]    NCHAN_EXT = (ADDR_WIDTH + 1)'(NCHAN);

   logic [GCNT_WIDTH-1:0]  gcnt;
   logic                   terminal;
   logic [NCHAN-1:0]       prev;
   logic [NCHAN-1:0]       rise;
   logic [NCHAN-1:0]       at_max;
   logic [NCHAN-1:0]       ovf_run;
   logic [NCHAN-1:0]       latched_ovf;
   logic [COUNT_WIDTH-1:0] count   [NCHAN];
   logic [COUNT_WIDTH-1:0] latched [NCHAN];
   logic                   addr_ok;

   // NOTE: every always_comb output gets a default before any conditional
   // or loop assignment, so no path can leave it unassigned and infer a latch.
   always_comb begin
      at_max   = '0;
      terminal = (gcnt == GCNT_LAST);
      // A retrigger while the stretched pulse is already high is not an edge;
      // this is where the one-shot dead time comes from.
      rise     = scal_i & ~prev;
      addr_ok  = ({1'b0, rd_addr_i} < NCHAN_EXT);
      for (int ch = 0; ch < NCHAN; ch++) begin
         at_max[ch] = (count[ch] == CNT_MAX);
      end
   end

   // Gate window timing, sequence number and window-done pulse.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk250_i) begin
      if (rst_i) begin
         gcnt   <= '0;
         seq_o  <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= terminal;
         if (terminal) begin
            gcnt  <= '0;
            seq_o <= seq_o + 8'd1;
         end else begin
            gcnt  <= gcnt + GCNT_ONE;
         end
      end
   end

   // Per-channel edge counters and window latches.
   always_ff @(posedge clk250_i) begin
      if (rst_i) begin
         // prev resets high so an input already high at reset release is
         // not mistaken for a rising edge.
         prev        <= '1;
         ovf_run     <= '0;
         latched_ovf <= '0;
         // NOTE: the count and latch arrays are reset explicitly; a read
         // straight after reset must return zero, not power-up contents.
         for (int ch = 0; ch < NCHAN; ch++) begin
            count[ch]   <= '0;
            latched[ch] <= '0;
         end
      end else begin
         prev <= scal_i;
         for (int ch = 0; ch < NCHAN; ch++) begin
            if (terminal) begin
               // An edge on the terminal cycle belongs to the closing window.
               latched[ch]     <= (rise[ch] && !at_max[ch]) ? count[ch] + CNT_ONE
                                                            : count[ch];
               latched_ovf[ch] <= ovf_run[ch] | (rise[ch] & at_max[ch]);
               count[ch]       <= '0;
               ovf_run[ch]     <= 1'b0;
            end else if (rise[ch]) begin
               if (at_max[ch]) begin
                  ovf_run[ch] <= 1'b1;
               end else begin
                  count[ch]   <= count[ch] + CNT_ONE;
               end
            end
         end
      end
   end

   // Registered read port. A read on the terminal cycle samples the latches
   // before they update, so it returns the previous window.
   always_ff @(posedge clk250_i) begin
      if (rst_i) begin
         rd_ack_o  <= 1'b0;
         rd_data_o <= '0;
         rd_ovf_o  <= 1'b0;
      end else begin
         rd_ack_o <= rd_i;
         if (rd_i) begin
            if (addr_ok) begin
               rd_data_o <= latched[rd_addr_i];
               rd_ovf_o  <= latched_ovf[rd_addr_i];
            end else begin
               rd_data_o <= '0;
               rd_ovf_o  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_scal_counter.sv
// -----------------------------------------------------------------------------
// tb_scal_counter
//
// Directed bench for scal_counter with a 100-cycle gate window and 3-bit
// counts (saturating at 7). Five channels give a 3-bit read address, so
// addresses 5..7 are genuinely out of range.
// cyc counts clk250_i edges since reset release; the edge numbered k runs
// with gcnt = (k-1) mod 100, so inputs driven while cyc == 99 land on the
// terminal cycle, and done_o is visible after edge 100, 200, ...
// -----------------------------------------------------------------------------
module tb_scal_counter;

   localparam int NCHAN = 5;
   localparam int CW    = 3;
   localparam int GATE  = 100;
   localparam int AW    = 3;

   logic          clk250_i = 1'b0;
   logic          rst_i;
   logic [NCHAN-1:0] scal_i;
   logic          rd_i;
   logic [AW-1:0] rd_addr_i;
   logic [CW-1:0] rd_data_o;
   logic          rd_ovf_o;
   logic          rd_ack_o;
   logic          done_o;
   logic [7:0]    seq_o;

   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;
   int         at;
   logic [7:0] exp_seq;

   always #2 clk250_i = ~clk250_i;

   scal_counter #(
      .NCHAN       (NCHAN),
      .COUNT_WIDTH (CW),
      .GATE_CYCLES (GATE),
      .ADDR_WIDTH  (AW)
   ) dut (
      .clk250_i  (clk250_i),
      .rst_i     (rst_i),
      .scal_i    (scal_i),
      .rd_i      (rd_i),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (rd_data_o),
      .rd_ovf_o  (rd_ovf_o),
      .rd_ack_o  (rd_ack_o),
      .done_o    (done_o),
      .seq_o     (seq_o)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk250_i);
      #1;
      cyc++;
   endtask

   task automatic idle_until(input int target);
      while (cyc < target) tick();
   endtask

   task automatic pulse(input int ch, input int hi, input int lo);
      scal_i[ch] = 1'b1;
      repeat (hi) tick();
      scal_i[ch] = 1'b0;
      repeat (lo) tick();
   endtask

   // Single read: strobe for one cycle, then compare the acked response.
   task automatic read_expect(input logic [AW-1:0] addr, input logic [CW-1:0] exp_data,
                              input logic exp_ovf, input string name);
      rd_i      = 1'b1;
      rd_addr_i = addr;
      tick();
      rd_i = 1'b0;
      checks++;
      if (rd_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL %s ack: got %b expected 1", name, rd_ack_o);
      end
      checks++;
      if ({rd_ovf_o, rd_data_o} !== {exp_ovf, exp_data}) begin
         errors++;
         $display("FAIL %s data: got ovf=%b data=%0d expected ovf=%b data=%0d",
                  name, rd_ovf_o, rd_data_o, exp_ovf, exp_data);
      end
   endtask

   // Bounded wait for done_o; at stays -1 if it never arrives.
   task automatic wait_done(output int found);
      found = -1;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (done_o === 1'b1) begin
            found = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_i     = 1'b1;
      rd_i      = 1'b0;
      rd_addr_i = '0;
      scal_i    = 5'b00010;  // ch1 high across reset release
      repeat (3) tick();
      checks++;
      if (rd_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", rd_ack_o); end
      checks++;
      if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
      checks++;
      if (rd_data_o !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", rd_data_o); end
      checks++;
      if (rd_ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", rd_ovf_o); end
      checks++;
      if (seq_o !== 8'd0) begin errors++; $display("FAIL reset_seq: got %0d expected 0", seq_o); end
      rst_i = 1'b0;
      cyc   = 0;
   endtask

   task automatic test_basic_count();
      // Window 1: five 8-high/8-low pulses on ch0, ch1 held high throughout.
      idle_until(2);
      repeat (5) pulse(0, 8, 8);
      wait_done(at);
      checks++;
      if (at !== 100) begin errors++; $display("FAIL w1_done_time: got cyc %0d expected 100", at); end
      checks++;
      if (seq_o !== 8'd1) begin errors++; $display("FAIL w1_seq: got %0d expected 1", seq_o); end
      tick();
      checks++;
      if (done_o !== 1'b0) begin errors++; $display("FAIL w1_done_width: got %b expected 0", done_o); end
      read_expect(3'd0, 3'd5, 1'b0, "w1_ch0");
      tick();
      checks++;
      if (rd_ack_o !== 1'b0) begin errors++; $display("FAIL hold_ack: got %b expected 0", rd_ack_o); end
      checks++;
      if (rd_data_o !== 3'd5) begin errors++; $display("FAIL hold_data: got %0d expected 5", rd_data_o); end
   endtask

   task automatic test_held_high();
      read_expect(3'd1, 3'd0, 1'b0, "w1_ch1_held_high");
      scal_i[1] = 1'b0;
      tick();
      pulse(1, 4, 4);
      wait_done(at);
      checks++;
      if (at !== 200) begin errors++; $display("FAIL w2_done_time: got cyc %0d expected 200", at); end
      read_expect(3'd1, 3'd1, 1'b0, "w2_ch1_clean_pulse");
      read_expect(3'd0, 3'd0, 1'b0, "w2_ch0_idle");
   endtask

   task automatic test_terminal_edge();
      // Window 3: three pulses on ch1, then a ch3 edge on the terminal cycle.
      repeat (3) pulse(1, 2, 2);
      idle_until(GATE * 3 - 1);
      scal_i[3] = 1'b1;
      tick();
      checks++;
      if (done_o !== 1'b1) begin errors++; $display("FAIL w3_done: got %b expected 1", done_o); end
      checks++;
      if (seq_o !== 8'd3) begin errors++; $display("FAIL w3_seq: got %0d expected 3", seq_o); end
      repeat (3) tick();
      scal_i[3] = 1'b0;
      read_expect(3'd3, 3'd1, 1'b0, "w3_ch3_terminal_edge");
      read_expect(3'd1, 3'd3, 1'b0, "w3_ch1");
   endtask

   task automatic test_back_to_back();
      // Window 4: six pulses on ch1, then a burst of reads starting on the
      // terminal cycle.
      repeat (6) pulse(1, 2, 2);
      idle_until(GATE * 4 - 1);
      rd_i      = 1'b1;
      rd_addr_i = 3'd1;
      tick();
      checks++;
      if ({rd_ack_o, done_o} !== 2'b11) begin
         errors++; $display("FAIL coincident_ack_done: got ack=%b done=%b expected 1 1", rd_ack_o, done_o);
      end
      checks++;
      if ({rd_ovf_o, rd_data_o} !== {1'b0, 3'd3}) begin
         errors++; $display("FAIL coincident_read: got %0d expected 3 (previous window)", rd_data_o);
      end
      rd_addr_i = 3'd5;
      tick();
      checks++;
      if ({rd_ack_o, rd_ovf_o, rd_data_o} !== {1'b1, 1'b0, 3'd0}) begin
         errors++; $display("FAIL out_of_range: got ack=%b ovf=%b data=%0d expected 1 0 0",
                            rd_ack_o, rd_ovf_o, rd_data_o);
      end
      rd_addr_i = 3'd3;
      tick();
      checks++;
      if ({rd_ack_o, rd_data_o} !== {1'b1, 3'd0}) begin
         errors++; $display("FAIL w4_ch3_next_window: got ack=%b data=%0d expected 1 0", rd_ack_o, rd_data_o);
      end
      rd_addr_i = 3'd1;
      tick();
      checks++;
      if ({rd_ack_o, rd_data_o} !== {1'b1, 3'd6}) begin
         errors++; $display("FAIL w4_ch1_b2b: got ack=%b data=%0d expected 1 6", rd_ack_o, rd_data_o);
      end
      rd_i = 1'b0;
      tick();
      checks++;
      if ({rd_ack_o, rd_data_o} !== {1'b0, 3'd6}) begin
         errors++; $display("FAIL b2b_hold: got ack=%b data=%0d expected 0 6", rd_ack_o, rd_data_o);
      end
   endtask

   task automatic test_saturation();
      // Window 5: ten edges on ch2 saturate at 7 with overflow.
      repeat (10) pulse(2, 1, 1);
      wait_done(at);
      checks++;
      if (at !== 500) begin errors++; $display("FAIL w5_done_time: got cyc %0d expected 500", at); end
      read_expect(3'd2, 3'd7, 1'b1, "w5_ch2_saturated");
      // Window 6: two simultaneous edges on every channel.
      repeat (2) begin
         scal_i = '1;
         tick();
         scal_i = '0;
         tick();
      end
      wait_done(at);
      checks++;
      if (at !== 600) begin errors++; $display("FAIL w6_done_time: got cyc %0d expected 600", at); end
      read_expect(3'd2, 3'd2, 1'b0, "w6_ch2_clean");
      read_expect(3'd0, 3'd2, 1'b0, "w6_ch0_simultaneous");
      read_expect(3'd4, 3'd2, 1'b0, "w6_ch4_simultaneous");
      // Window 7: ch4 reaches max and overflows only via a terminal edge;
      // ch0 reaches max exactly with no overflow.
      repeat (7) pulse(4, 1, 1);
      repeat (7) pulse(0, 1, 1);
      idle_until(GATE * 7 - 1);
      scal_i[4] = 1'b1;
      tick();
      scal_i[4] = 1'b0;
      checks++;
      if (done_o !== 1'b1) begin errors++; $display("FAIL w7_done: got %b expected 1", done_o); end
      read_expect(3'd4, 3'd7, 1'b1, "w7_ch4_terminal_ovf");
      read_expect(3'd0, 3'd7, 1'b0, "w7_ch0_exact_max");
   endtask

   task automatic test_reset_mid_window();
      // Window 8: pending counts on ch0, a nonzero read, then reset at
      // gcnt=50 together with a read strobe.
      repeat (3) pulse(0, 2, 2);
      read_expect(3'd4, 3'd7, 1'b1, "w8_pre_reset_read");
      idle_until(GATE * 7 + 50);
      rst_i     = 1'b1;
      rd_i      = 1'b1;
      rd_addr_i = 3'd4;
      tick();
      rst_i = 1'b0;
      rd_i  = 1'b0;
      cyc   = 0;
      checks++;
      if ({rd_ack_o, done_o, rd_ovf_o} !== 3'b000) begin
         errors++; $display("FAIL midreset_flags: got ack=%b done=%b ovf=%b expected 0 0 0",
                            rd_ack_o, done_o, rd_ovf_o);
      end
      checks++;
      if ({seq_o, rd_data_o} !== 11'd0) begin
         errors++; $display("FAIL midreset_values: got seq=%0d data=%0d expected 0 0", seq_o, rd_data_o);
      end
      wait_done(at);
      checks++;
      if (at !== 100) begin errors++; $display("FAIL midreset_window: got cyc %0d expected 100", at); end
      checks++;
      if (seq_o !== 8'd1) begin errors++; $display("FAIL midreset_seq: got %0d expected 1", seq_o); end
      read_expect(3'd0, 3'd0, 1'b0, "midreset_ch0_cleared");
      read_expect(3'd4, 3'd0, 1'b0, "midreset_ch4_cleared");
   endtask

   task automatic test_seq_wrap();
      exp_seq = 8'd1;
      for (int i = 0; i < 256; i++) begin
         wait_done(at);
         exp_seq = exp_seq + 8'd1;
         checks++;
         if (at !== (i + 2) * GATE) begin
            errors++; $display("FAIL seq_period_%0d: got cyc %0d expected %0d", i, at, (i + 2) * GATE);
         end
         checks++;
         if (seq_o !== exp_seq) begin
            errors++; $display("FAIL seq_step_%0d: got %0d expected %0d", i, seq_o, exp_seq);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_count();
      test_held_high();
      test_terminal_edge();
      test_back_to_back();
      test_saturation();
      test_reset_mid_window();
      test_seq_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
